// File: rtl/riscv_membuf_rsp.sv
// Memory-side responder for the CPU memory access buffer. Requests are
// queued in order, issued one at a time to a wait-stated slave, and each
// access returns exactly one registered response. A stalled access is
// force-completed with an error response once its wait budget runs out.
module riscv_membuf_rsp #(
  parameter int DEPTH   = 2,
  parameter int DBITS   = 64,
  parameter int ABITS   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             rst_ni,
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             ena_i,
  input  logic             req_i,
  input  logic             we_i,
  input  logic [ABITS-1:0] addr_i,
  input  logic [DBITS-1:0] d_i,
  output logic             ack_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [ABITS-1:0] mem_addr_o,
  output logic [DBITS-1:0] mem_d_o,
  input  logic             mem_ready_i,
  input  logic [DBITS-1:0] mem_q_i,
  output logic             rsp_valid_o,
  output logic             rsp_we_o,
  output logic             rsp_err_o,
  output logic [DBITS-1:0] rsp_q_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int IW = (AW > 0) ? AW : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int EW = 1 + ABITS + DBITS;

  typedef enum logic {IDLE, ACCESS} state_t;

  logic [EW-1:0]    buf_q [DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q, wptr_nxt, rptr_nxt;
  logic [IW-1:0]    widx, ridx;
  logic [CW-1:0]    cnt_q;
  state_t           state_q, state_d;
  logic [EW-1:0]    head;
  logic             head_we;
  logic             tmo_hit, pop;
  logic             rsp_valid_p1, rsp_we_p1, rsp_err_p1;
  logic [DBITS-1:0] rsp_q_p1;

  // The pointer MSB is the wrap bit; the low bits index the buffer.
  assign widx     = IW'(wptr_q & PW'(DEPTH - 1));
  assign ridx     = IW'(rptr_q & PW'(DEPTH - 1));
  assign empty_o  = (wptr_q == rptr_q);
  assign full_o   = ((wptr_q - rptr_q) == PW'(DEPTH));

  assign head     = buf_q[ridx];
  assign head_we  = head[EW-1];

  assign mem_req_o  = (state_q == ACCESS) & ena_i & ~clr_i;
  assign mem_we_o   = head_we;
  assign mem_addr_o = head[EW-2 -: ABITS];
  assign mem_d_o    = head[DBITS-1:0];

  // A forced completion only happens on a cycle the slave did not finish.
  assign tmo_hit  = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT)) && !mem_ready_i;
  assign pop      = mem_req_o & (mem_ready_i | tmo_hit);

  // A pop frees the head slot in the same cycle, so a full queue can still accept.
  assign ack_o    = req_i & ena_i & ~clr_i & (~full_o | pop);

  assign wptr_nxt = wptr_q + PW'(ack_o);
  assign rptr_nxt = rptr_q + PW'(pop);

  // Issue FSM next state: enter ACCESS as soon as an entry exists after this edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if ((~empty_o | ack_o) & ena_i & ~clr_i) state_d = ACCESS;
      ACCESS:  if (clr_i) state_d = IDLE;
               else if (pop && (wptr_nxt == rptr_nxt)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Queue storage: payload only, written on acceptance.
  always_ff @(posedge clk_i) begin
    if (ack_o) buf_q[widx] <= {we_i, addr_i, d_i};
  end

  // Queue pointers; a clear drops every entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (clr_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_nxt;
      rptr_q <= rptr_nxt;
    end
  end

  // Wait-state counter: counts stalled request cycles, frozen while disabled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (ena_i) begin
      if (pop || (state_q == IDLE))                           cnt_q <= '0;
      else if (mem_req_o && !mem_ready_i && (TIMEOUT != 0))   cnt_q <= cnt_q + 1'b1;
    end
  end

  // ---- stage p1: registered response, one cycle after completion ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_p1 <= 1'b0;
      rsp_we_p1    <= 1'b0;
      rsp_err_p1   <= 1'b0;
      rsp_q_p1     <= '0;
    end else if (pop) begin
      rsp_valid_p1 <= 1'b1;
      rsp_we_p1    <= head_we;
      rsp_err_p1   <= ~mem_ready_i;
      rsp_q_p1     <= (mem_ready_i && !head_we) ? mem_q_i : '0;
    end else begin
      rsp_valid_p1 <= 1'b0;
    end
  end

  assign rsp_valid_o = rsp_valid_p1;
  assign rsp_we_o    = rsp_we_p1;
  assign rsp_err_o   = rsp_err_p1;
  assign rsp_q_o     = rsp_q_p1;

endmodule

// File: tb/tb_riscv_membuf_rsp.sv
// Bench for riscv_membuf_rsp: directed cycle-by-cycle stimulus with a
// response scoreboard checked by an independent monitor.
module tb_riscv_membuf_rsp;

  logic        rst_ni, clk_i, clr_i, ena_i, req_i, we_i;
  logic [31:0] addr_i;
  logic [63:0] d_i;
  logic        ack_o, mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o;
  logic [63:0] mem_d_o;
  logic        mem_ready_i;
  logic [63:0] mem_q_i;
  logic        rsp_valid_o, rsp_we_o, rsp_err_o;
  logic [63:0] rsp_q_o;
  logic        empty_o, full_o;

  logic        use_tbl;
  logic [63:0] q_drv;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic        we;
    logic        err;
    logic [63:0] q;
  } rsp_t;
  rsp_t exp_q[$];

  riscv_membuf_rsp #(.DEPTH(2), .DBITS(64), .ABITS(32), .TIMEOUT(3)) dut (
    .rst_ni(rst_ni), .clk_i(clk_i), .clr_i(clr_i), .ena_i(ena_i),
    .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .d_i(d_i), .ack_o(ack_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_d_o(mem_d_o), .mem_ready_i(mem_ready_i), .mem_q_i(mem_q_i),
    .rsp_valid_o(rsp_valid_o), .rsp_we_o(rsp_we_o), .rsp_err_o(rsp_err_o),
    .rsp_q_o(rsp_q_o), .empty_o(empty_o), .full_o(full_o)
  );

  // Table-driven read data: tag in the upper word, address in the lower.
  assign mem_q_i = use_tbl ? {32'hC0DE_0000, mem_addr_o} : q_drv;

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_i);
  endtask

  task automatic issue(input logic we, input logic [31:0] a, input logic [63:0] d);
    req_i  = 1'b1;
    we_i   = we;
    addr_i = a;
    d_i    = d;
  endtask

  task automatic push_exp(input logic we, input logic err, input logic [63:0] q);
    rsp_t r;
    r.we  = we;
    r.err = err;
    r.q   = q;
    exp_q.push_back(r);
  endtask

  // Monitor: every response strobe must match the oldest expected response.
  always @(negedge clk_i) begin
    if (rst_ni && rsp_valid_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rsp_unexpected: got we=%0b err=%0b q=%0h expected no response at %0t",
                 rsp_we_o, rsp_err_o, rsp_q_o, $time);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        if (rsp_we_o !== e.we || rsp_err_o !== e.err || rsp_q_o !== e.q) begin
          failures++;
          $display("FAIL rsp_data: got we=%0b err=%0b q=%0h expected we=%0b err=%0b q=%0h at %0t",
                   rsp_we_o, rsp_err_o, rsp_q_o, e.we, e.err, e.q, $time);
        end
      end
    end
  end

  initial begin
    rst_ni = 1'b0; clr_i = 1'b0; ena_i = 1'b1; req_i = 1'b0; we_i = 1'b0;
    addr_i = '0; d_i = '0; mem_ready_i = 1'b0; q_drv = '0; use_tbl = 1'b0;

    // Reset state
    next_cycle();
    sample();
    chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("rst_rsp_we",    64'(rsp_we_o),    64'd0);
    chk("rst_rsp_err",   64'(rsp_err_o),   64'd0);
    chk("rst_rsp_q",     rsp_q_o,          64'd0);
    chk("rst_empty",     64'(empty_o),     64'd1);
    chk("rst_full",      64'(full_o),      64'd0);
    chk("rst_mem_req",   64'(mem_req_o),   64'd0);
    next_cycle();
    rst_ni = 1'b1;
    next_cycle();

    // Single read
    issue(1'b0, 32'h100, 64'd0);
    sample(); chk("t1_ack", 64'(ack_o), 64'd1);
    push_exp(1'b0, 1'b0, 64'hDEAD);
    next_cycle(); req_i = 1'b0;
    sample(); chk("t1_mem_req_c1", 64'(mem_req_o), 64'd1);
    chk("t1_mem_addr", 64'(mem_addr_o), 64'h100);
    chk("t1_mem_we", 64'(mem_we_o), 64'd0);
    next_cycle();
    sample(); chk("t1_mem_req_c2", 64'(mem_req_o), 64'd1);
    next_cycle(); mem_ready_i = 1'b1; q_drv = 64'hDEAD;
    sample(); chk("t1_no_rsp_yet", 64'(rsp_valid_o), 64'd0);
    next_cycle(); mem_ready_i = 1'b0; q_drv = '0;
    sample(); chk("t1_rsp_valid", 64'(rsp_valid_o), 64'd1);
    chk("t1_empty", 64'(empty_o), 64'd1);
    chk("t1_mem_req_idle", 64'(mem_req_o), 64'd0);
    next_cycle();
    sample(); chk("t1_rsp_one_cycle", 64'(rsp_valid_o), 64'd0);
    next_cycle();

    // Fill / backpressure with three writes
    issue(1'b1, 32'h10, 64'h1111);
    sample(); chk("t2_ack_a", 64'(ack_o), 64'd1);
    push_exp(1'b1, 1'b0, 64'd0);
    next_cycle(); issue(1'b1, 32'h20, 64'h2222);
    sample(); chk("t2_ack_b", 64'(ack_o), 64'd1);
    chk("t2_mem_addr_a", 64'(mem_addr_o), 64'h10);
    chk("t2_mem_d_a", mem_d_o, 64'h1111);
    push_exp(1'b1, 1'b0, 64'd0);
    next_cycle(); issue(1'b1, 32'h30, 64'h3333);
    sample(); chk("t2_full", 64'(full_o), 64'd1);
    chk("t2_ack_c_held", 64'(ack_o), 64'd0);
    next_cycle(); mem_ready_i = 1'b1;
    sample(); chk("t2_ack_c_on_pop", 64'(ack_o), 64'd1);
    push_exp(1'b1, 1'b0, 64'd0);
    next_cycle(); req_i = 1'b0; mem_ready_i = 1'b0;
    sample(); chk("t2_full_again", 64'(full_o), 64'd1);
    chk("t2_mem_addr_b", 64'(mem_addr_o), 64'h20);
    chk("t2_mem_d_b", mem_d_o, 64'h2222);
    chk("t2_mem_we_b", 64'(mem_we_o), 64'd1);
    next_cycle(); mem_ready_i = 1'b1;
    sample();
    next_cycle();
    sample(); chk("t2_mem_addr_c", 64'(mem_addr_o), 64'h30);
    next_cycle(); mem_ready_i = 1'b0;
    sample(); chk("t2_empty", 64'(empty_o), 64'd1);
    next_cycle(); next_cycle();

    // Back-to-back reads with the slave always ready
    use_tbl = 1'b1; mem_ready_i = 1'b1;
    issue(1'b0, 32'h200, 64'd0);
    sample(); chk("t3_ack0", 64'(ack_o), 64'd1);
    push_exp(1'b0, 1'b0, 64'hC0DE0000_00000200);
    next_cycle(); issue(1'b0, 32'h204, 64'd0);
    sample(); chk("t3_ack1", 64'(ack_o), 64'd1);
    chk("t3_mem_req1", 64'(mem_req_o), 64'd1);
    push_exp(1'b0, 1'b0, 64'hC0DE0000_00000204);
    next_cycle(); issue(1'b0, 32'h208, 64'd0);
    sample(); chk("t3_ack2", 64'(ack_o), 64'd1);
    chk("t3_mem_req2", 64'(mem_req_o), 64'd1);
    chk("t3_rsp_valid2", 64'(rsp_valid_o), 64'd1);
    push_exp(1'b0, 1'b0, 64'hC0DE0000_00000208);
    next_cycle(); issue(1'b0, 32'h20C, 64'd0);
    sample(); chk("t3_ack3", 64'(ack_o), 64'd1);
    chk("t3_mem_req3", 64'(mem_req_o), 64'd1);
    chk("t3_rsp_valid3", 64'(rsp_valid_o), 64'd1);
    push_exp(1'b0, 1'b0, 64'hC0DE0000_0000020C);
    next_cycle(); req_i = 1'b0;
    sample(); chk("t3_mem_req4", 64'(mem_req_o), 64'd1);
    chk("t3_rsp_valid4", 64'(rsp_valid_o), 64'd1);
    next_cycle(); mem_ready_i = 1'b0;
    sample(); chk("t3_mem_req_done", 64'(mem_req_o), 64'd0);
    chk("t3_rsp_valid5", 64'(rsp_valid_o), 64'd1);
    next_cycle(); use_tbl = 1'b0;
    next_cycle();

    // Timeout with TIMEOUT=3, then the next queued entry issues
    q_drv = 64'hBAD;
    issue(1'b0, 32'h300, 64'd0);
    sample(); chk("t4_ack_a", 64'(ack_o), 64'd1);
    push_exp(1'b0, 1'b1, 64'd0);
    next_cycle(); issue(1'b0, 32'h304, 64'd0);
    sample(); chk("t4_ack_b", 64'(ack_o), 64'd1);
    push_exp(1'b0, 1'b0, 64'h5555);
    next_cycle(); req_i = 1'b0;
    sample();
    next_cycle();
    sample(); chk("t4_no_early_rsp", 64'(rsp_valid_o), 64'd0);
    next_cycle();
    sample(); chk("t4_limit_mem_addr", 64'(mem_addr_o), 64'h300);
    chk("t4_limit_no_rsp", 64'(rsp_valid_o), 64'd0);
    next_cycle(); mem_ready_i = 1'b1; q_drv = 64'h5555;
    sample(); chk("t4_err_rsp_valid", 64'(rsp_valid_o), 64'd1);
    chk("t4_next_mem_req", 64'(mem_req_o), 64'd1);
    chk("t4_next_mem_addr", 64'(mem_addr_o), 64'h304);
    next_cycle(); mem_ready_i = 1'b0; q_drv = '0;
    sample(); chk("t4_empty", 64'(empty_o), 64'd1);
    next_cycle();

    // Clear mid-access with a coincident ready
    issue(1'b0, 32'h400, 64'd0);
    sample(); chk("t5_ack_a", 64'(ack_o), 64'd1);
    next_cycle(); issue(1'b0, 32'h404, 64'd0);
    sample(); chk("t5_ack_b", 64'(ack_o), 64'd1);
    next_cycle(); issue(1'b0, 32'h408, 64'd0); clr_i = 1'b1; mem_ready_i = 1'b1; q_drv = 64'h9999;
    sample(); chk("t5_clr_mem_req", 64'(mem_req_o), 64'd0);
    chk("t5_clr_ack", 64'(ack_o), 64'd0);
    next_cycle(); req_i = 1'b0; clr_i = 1'b0; mem_ready_i = 1'b0; q_drv = '0;
    sample(); chk("t5_empty", 64'(empty_o), 64'd1);
    chk("t5_mem_req_off", 64'(mem_req_o), 64'd0);
    chk("t5_no_rsp", 64'(rsp_valid_o), 64'd0);
    next_cycle();
    sample(); chk("t5_mem_req_still_off", 64'(mem_req_o), 64'd0);
    next_cycle();

    // Stall during ACCESS: counter frozen, no error on resume
    issue(1'b0, 32'h500, 64'd0);
    sample(); chk("t6_ack", 64'(ack_o), 64'd1);
    push_exp(1'b0, 1'b0, 64'h7777);
    next_cycle(); req_i = 1'b0;
    sample();
    next_cycle();
    sample();
    for (int i = 0; i < 5; i++) begin
      next_cycle(); ena_i = 1'b0;
      if (i == 1) issue(1'b0, 32'h504, 64'd0);
      else        req_i = 1'b0;
      sample(); chk("t6_stall_mem_req", 64'(mem_req_o), 64'd0);
      if (i == 1) chk("t6_stall_ack", 64'(ack_o), 64'd0);
    end
    next_cycle(); ena_i = 1'b1; req_i = 1'b0;
    sample(); chk("t6_resume_mem_req", 64'(mem_req_o), 64'd1);
    chk("t6_resume_no_rsp", 64'(rsp_valid_o), 64'd0);
    next_cycle(); mem_ready_i = 1'b1; q_drv = 64'h7777;
    sample(); chk("t6_mem_addr", 64'(mem_addr_o), 64'h500);
    next_cycle(); mem_ready_i = 1'b0; q_drv = '0;
    sample(); chk("t6_rsp_valid", 64'(rsp_valid_o), 64'd1);
    chk("t6_empty", 64'(empty_o), 64'd1);
    next_cycle(); next_cycle();

    chk("all_rsp_seen", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
